// File: rtl/pipe_perf_monitor.sv
// rtl/pipe_perf_monitor.sv - run-control FSM with saturating cycle/stall/flush/retire counters and PC hang detector
module pipe_perf_monitor #(
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 30,
  parameter int HANG_LIMIT = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic             flush_i,
  input  logic             retire_i,
  input  logic [31:0]      pc_i,
  output logic [CNT_W-1:0] cycle_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] retire_cnt_o,
  output logic [1:0]       state_o,
  output logic             done_o,
  output logic             hang_o,
  output logic             ovf_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] BUDGET   = CNT_W'(MAX_CYCLES);
  localparam logic [31:0]      HANG_LIM = 32'(HANG_LIMIT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
  logic             done_q, done_d;
  logic             hang_q, hang_d;
  logic             ovf_q, ovf_d;
  logic [31:0]      pc_prev_q, pc_prev_d;
  logic             pc_prev_valid_q, pc_prev_valid_d;
  logic [31:0]      hang_cnt_q, hang_cnt_d;
  logic             count_en;

  // Next-state, counter updates, budget and hang termination
  always_comb begin
    state_d         = state_q;
    cycle_d         = cycle_q;
    stall_cnt_d     = stall_cnt_q;
    flush_cnt_d     = flush_cnt_q;
    retire_cnt_d    = retire_cnt_q;
    done_d          = done_q;
    hang_d          = hang_q;
    ovf_d           = ovf_q;
    pc_prev_d       = pc_prev_q;
    pc_prev_valid_d = pc_prev_valid_q;
    hang_cnt_d      = hang_cnt_q;
    count_en        = (state_q == ST_RUN) && start_i;

    case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_RUN;
      ST_RUN:   if (!start_i) state_d = ST_PAUSE;
      ST_PAUSE: if (start_i) state_d = ST_RUN;
      default:  state_d = ST_DONE;
    endcase

    if (count_en) begin
      // Each counter sticks at all-ones; an increment attempted there flags overflow
      if (cycle_q == CNT_MAX) ovf_d = 1'b1;
      else cycle_d = cycle_q + 1'b1;

      if (stall_i && !branch_i) begin
        if (stall_cnt_q == CNT_MAX) ovf_d = 1'b1;
        else stall_cnt_d = stall_cnt_q + 1'b1;
      end

      if (flush_i) begin
        if (flush_cnt_q == CNT_MAX) ovf_d = 1'b1;
        else flush_cnt_d = flush_cnt_q + 1'b1;
      end

      if (retire_i) begin
        if (retire_cnt_q == CNT_MAX) ovf_d = 1'b1;
        else retire_cnt_d = retire_cnt_q + 1'b1;
      end

      if ((MAX_CYCLES != 0) && (cycle_d == BUDGET)) begin
        done_d  = 1'b1;
        state_d = ST_DONE;
      end

      if (HANG_LIMIT != 0) begin
        if (pc_prev_valid_q && (pc_i == pc_prev_q) && !stall_i) hang_cnt_d = hang_cnt_q + 32'd1;
        else hang_cnt_d = 32'd0;
        pc_prev_d       = pc_i;
        pc_prev_valid_d = 1'b1;
        if (hang_cnt_d == HANG_LIM) begin
          hang_d  = 1'b1;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
    end
  end

  // State register with synchronous active-high reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= ST_IDLE;
      cycle_q         <= '0;
      stall_cnt_q     <= '0;
      flush_cnt_q     <= '0;
      retire_cnt_q    <= '0;
      done_q          <= 1'b0;
      hang_q          <= 1'b0;
      ovf_q           <= 1'b0;
      pc_prev_q       <= 32'd0;
      pc_prev_valid_q <= 1'b0;
      hang_cnt_q      <= 32'd0;
    end else begin
      state_q         <= state_d;
      cycle_q         <= cycle_d;
      stall_cnt_q     <= stall_cnt_d;
      flush_cnt_q     <= flush_cnt_d;
      retire_cnt_q    <= retire_cnt_d;
      done_q          <= done_d;
      hang_q          <= hang_d;
      ovf_q           <= ovf_d;
      pc_prev_q       <= pc_prev_d;
      pc_prev_valid_q <= pc_prev_valid_d;
      hang_cnt_q      <= hang_cnt_d;
    end
  end

  assign cycle_o      = cycle_q;
  assign stall_cnt_o  = stall_cnt_q;
  assign flush_cnt_o  = flush_cnt_q;
  assign retire_cnt_o = retire_cnt_q;
  assign state_o      = state_q;
  assign done_o       = done_q;
  assign hang_o       = hang_q;
  assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// tb/tb_pipe_perf_monitor.sv - self-checking bench for pipe_perf_monitor over three parameter sets
module tb_pipe_perf_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic        flush = 1'b0;
  logic        retire = 1'b0;
  logic [31:0] pc = 32'h0;
  bit          pc_walk = 1'b1;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  // u0: default budget 30, hang 16; u1: unlimited, hang 4; u2: 4-bit counters, unlimited
  logic [31:0] cyc0, stl0, fl0, ret0;
  logic [31:0] cyc1, stl1, fl1, ret1;
  logic [3:0]  cyc2, stl2, fl2, ret2;
  logic [1:0]  st0, st1, st2;
  logic        dn0, dn1, dn2, hg0, hg1, hg2, ov0, ov1, ov2;

  pipe_perf_monitor #(.CNT_W(32), .MAX_CYCLES(30), .HANG_LIMIT(16)) u0 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .branch_i(branch),
    .flush_i(flush), .retire_i(retire), .pc_i(pc),
    .cycle_o(cyc0), .stall_cnt_o(stl0), .flush_cnt_o(fl0), .retire_cnt_o(ret0),
    .state_o(st0), .done_o(dn0), .hang_o(hg0), .ovf_o(ov0));

  pipe_perf_monitor #(.CNT_W(32), .MAX_CYCLES(0), .HANG_LIMIT(4)) u1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .branch_i(branch),
    .flush_i(flush), .retire_i(retire), .pc_i(pc),
    .cycle_o(cyc1), .stall_cnt_o(stl1), .flush_cnt_o(fl1), .retire_cnt_o(ret1),
    .state_o(st1), .done_o(dn1), .hang_o(hg1), .ovf_o(ov1));

  pipe_perf_monitor #(.CNT_W(4), .MAX_CYCLES(0), .HANG_LIMIT(16)) u2 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .branch_i(branch),
    .flush_i(flush), .retire_i(retire), .pc_i(pc),
    .cycle_o(cyc2), .stall_cnt_o(stl2), .flush_cnt_o(fl2), .retire_cnt_o(ret2),
    .state_o(st2), .done_o(dn2), .hang_o(hg2), .ovf_o(ov2));

  // Reference model: per instance run mode, plain integer counters and flags
  int     m_maxc[3] = '{30, 0, 0};
  int     m_hl[3]   = '{16, 4, 16};
  longint m_lim[3]  = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
  int     m_state[3];
  longint m_cyc[3], m_stl[3], m_fl[3], m_ret[3];
  bit     m_done[3], m_hang[3], m_ovf[3], m_pv[3];
  logic [31:0] m_pcp[3];
  int     m_hc[3];

  function automatic longint bump(int i, longint v, bit en);
    if (!en) return v;
    if (v == m_lim[i]) begin
      m_ovf[i] = 1'b1;
      return v;
    end
    return v + 1;
  endfunction

  function automatic void model_step();
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_state[i] = 0; m_cyc[i] = 0; m_stl[i] = 0; m_fl[i] = 0; m_ret[i] = 0;
        m_done[i] = 0; m_hang[i] = 0; m_ovf[i] = 0; m_pv[i] = 0; m_pcp[i] = 0; m_hc[i] = 0;
      end else if (m_state[i] == 0 || m_state[i] == 2) begin
        if (start) m_state[i] = 1;
      end else if (m_state[i] == 1) begin
        if (!start) m_state[i] = 2;
        else begin
          m_cyc[i] = bump(i, m_cyc[i], 1'b1);
          m_stl[i] = bump(i, m_stl[i], stall && !branch);
          m_fl[i]  = bump(i, m_fl[i], flush);
          m_ret[i] = bump(i, m_ret[i], retire);
          if (m_maxc[i] != 0 && m_cyc[i] == longint'(m_maxc[i])) begin
            m_done[i] = 1; m_state[i] = 3;
          end
          if (m_hl[i] != 0) begin
            m_hc[i] = (m_pv[i] && pc == m_pcp[i] && !stall) ? m_hc[i] + 1 : 0;
            m_pcp[i] = pc;
            m_pv[i] = 1;
            if (m_hc[i] == m_hl[i]) begin
              m_hang[i] = 1; m_done[i] = 1; m_state[i] = 3;
            end
          end
        end
      end
    end
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_inst(int i, logic [63:0] c, logic [63:0] s, logic [63:0] f, logic [63:0] r,
                          logic [63:0] st, logic [63:0] d, logic [63:0] h, logic [63:0] o);
    chk($sformatf("u%0d_cycle", i),  c,  64'(m_cyc[i]));
    chk($sformatf("u%0d_stall", i),  s,  64'(m_stl[i]));
    chk($sformatf("u%0d_flush", i),  f,  64'(m_fl[i]));
    chk($sformatf("u%0d_retire", i), r,  64'(m_ret[i]));
    chk($sformatf("u%0d_state", i),  st, 64'(m_state[i]));
    chk($sformatf("u%0d_done", i),   d,  64'(m_done[i]));
    chk($sformatf("u%0d_hang", i),   h,  64'(m_hang[i]));
    chk($sformatf("u%0d_ovf", i),    o,  64'(m_ovf[i]));
  endtask

  task automatic check_all();
    chk_inst(0, 64'(cyc0), 64'(stl0), 64'(fl0), 64'(ret0), 64'(st0), 64'(dn0), 64'(hg0), 64'(ov0));
    chk_inst(1, 64'(cyc1), 64'(stl1), 64'(fl1), 64'(ret1), 64'(st1), 64'(dn1), 64'(hg1), 64'(ov1));
    chk_inst(2, 64'(cyc2), 64'(stl2), 64'(fl2), 64'(ret2), 64'(st2), 64'(dn2), 64'(hg2), 64'(ov2));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    if (pc_walk) pc = pc + 32'd4;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stall = 1'b0; branch = 1'b0; flush = 1'b0; retire = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("reset_cycle", 64'(cyc0), 64'd0);
    chk("reset_state", 64'(st0), 64'd0);
    chk("reset_done", 64'(dn0), 64'd0);

    // Basic run to budget, then hold
    start = 1'b1;
    tick();
    repeat (29) tick();
    chk("basic_not_done_29", 64'(dn0), 64'd0);
    tick();
    chk("basic_cycle", 64'(cyc0), 64'd30);
    chk("basic_done", 64'(dn0), 64'd1);
    chk("basic_state", 64'(st0), 64'd3);
    repeat (10) tick();
    chk("basic_hold_cycle", 64'(cyc0), 64'd30);
    chk("unlimited_cycle", 64'(cyc1), 64'd40);
    chk("sat_cycle", 64'(cyc2), 64'd15);
    chk("sat_ovf", 64'(ov2), 64'd1);
    chk("no_sat_ovf", 64'(ov0), 64'd0);

    // Qualified events
    do_reset();
    start = 1'b1;
    tick();
    stall = 1'b1; branch = 1'b0;
    for (int k = 0; k < 5; k++) begin
      flush = (k < 2);
      tick();
    end
    flush = 1'b0; branch = 1'b1;
    repeat (3) tick();
    stall = 1'b0; branch = 1'b0; retire = 1'b1;
    repeat (7) tick();
    retire = 1'b0;
    chk("ev_stall", 64'(stl0), 64'd5);
    chk("ev_flush", 64'(fl0), 64'd2);
    chk("ev_retire", 64'(ret0), 64'd7);
    chk("ev_cycle", 64'(cyc0), 64'd15);

    // Pause and resume
    do_reset();
    start = 1'b1;
    tick();
    repeat (10) tick();
    start = 1'b0;
    repeat (4) tick();
    chk("pause_cycle", 64'(cyc0), 64'd10);
    chk("pause_state", 64'(st0), 64'd2);
    start = 1'b1;
    tick();
    chk("resume_edge_cycle", 64'(cyc0), 64'd10);
    repeat (20) tick();
    chk("resume_cycle", 64'(cyc0), 64'd30);
    chk("resume_done", 64'(dn0), 64'd1);

    // Hang at constant PC, then stalled repeat never hangs
    do_reset();
    pc_walk = 1'b0; pc = 32'h40; start = 1'b1;
    tick();
    repeat (4) tick();
    chk("hang_not_yet", 64'(hg1), 64'd0);
    tick();
    chk("hang_flag", 64'(hg1), 64'd1);
    chk("hang_done", 64'(dn1), 64'd1);
    chk("hang_cycle", 64'(cyc1), 64'd5);
    chk("hang_state", 64'(st1), 64'd3);
    do_reset();
    stall = 1'b1; start = 1'b1;
    tick();
    repeat (40) tick();
    chk("stalled_no_hang", 64'(hg1), 64'd0);
    chk("stalled_no_done", 64'(dn1), 64'd0);
    stall = 1'b0;

    // Reset mid-run
    do_reset();
    pc_walk = 1'b1; start = 1'b1;
    tick();
    repeat (12) tick();
    chk("mid_cycle", 64'(cyc0), 64'd12);
    rst = 1'b1;
    tick();
    chk("mid_rst_cycle", 64'(cyc0), 64'd0);
    chk("mid_rst_state", 64'(st0), 64'd0);
    rst = 1'b0;
    tick();
    tick();
    chk("restart_cycle", 64'(cyc0), 64'd1);

    // Randomized traffic against the model
    do_reset();
    for (int k = 0; k < 600; k++) begin
      rst    = ($urandom_range(0, 59) == 0);
      start  = ($urandom_range(0, 7) != 0);
      stall  = ($urandom_range(0, 3) == 0);
      branch = ($urandom_range(0, 2) == 0);
      flush  = ($urandom_range(0, 4) == 0);
      retire = ($urandom_range(0, 1) == 0);
      pc_walk = 1'b0;
      pc = 32'($urandom_range(0, 1)) << 2;
      tick();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
